gen_sequencer: RTL and testbench

GEN_SEQUENCER -- requirements
Module: gen_sequencer

---
 rtl/gen_sequencer_if.sv | 35 +++
 rtl/gen_sequencer.sv | 119 +++++++++++
 tb/tb_gen_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_sequencer_if.sv
// gen_sequencer_if: seed load, board memory, row decoder and display signals of the Life sequencer
interface gen_sequencer_if;
    logic       load_valid;
    logic [7:0] load_row;
    logic       load_ready;
    logic       load_req;
    logic       run;
    logic       step;
    logic [2:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] dec_in;
    logic [7:0] dec_a;
    logic [7:0] dec_b;
    logic [7:0] dec_out;
    logic [7:0] disp_row;
    logic [2:0] disp_addr;
    logic       disp_valid;
    logic       busy;
    logic       gen_done;
    logic [15:0] gen_count;

    modport master (
        output load_valid, load_row, load_req, run, step, mem_rdata, dec_out,
        input  load_ready, mem_addr, mem_we, mem_wdata, dec_in, dec_a, dec_b,
        input  disp_row, disp_addr, disp_valid, busy, gen_done, gen_count
    );

    modport slave (
        input  load_valid, load_row, load_req, run, step, mem_rdata, dec_out,
        output load_ready, mem_addr, mem_we, mem_wdata, dec_in, dec_a, dec_b,
        output disp_row, disp_addr, disp_valid, busy, gen_done, gen_count
    );
endinterface

// File: rtl/gen_sequencer.sv
// gen_sequencer: Life board sequencer -- seed load, display scan, shadow fetch and in-place row update
module gen_sequencer #(
    parameter int FRAMES_PER_GEN = 64
) (
    input  logic           clk,
    input  logic           reset,
    gen_sequencer_if.slave bus
);
    typedef enum logic [1:0] {LOAD, DISPLAY, FETCH, UPDATE} state_t;
    localparam logic [7:0] FC_LAST = 8'(FRAMES_PER_GEN - 1);

    state_t      r_state, w_state_nx;
    logic [2:0]  r_rc, w_rc_nx;
    logic [7:0]  r_fc, w_fc_nx;
    logic        r_ftail, w_ftail_nx;
    logic        r_step_pend, w_enter_fetch;
    logic [15:0] r_gen_count;
    logic        r_gen_done, r_disp_valid;
    logic [2:0]  r_disp_addr;
    logic [7:0]  r_shadow [8];
    logic        w_last_update;

    assign w_last_update  = r_state == UPDATE && r_rc == 3'd7;
    assign bus.load_ready = r_state == LOAD;
    assign bus.busy       = r_state == FETCH || r_state == UPDATE;
    assign bus.gen_done   = r_gen_done;
    assign bus.gen_count  = r_gen_count;
    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_addr  = r_disp_addr;
    assign bus.disp_row   = bus.mem_rdata;

    // next state, row/frame counters and per-state memory and decoder drive
    always_comb begin
        w_state_nx    = r_state;
        w_rc_nx       = r_rc;
        w_fc_nx       = r_fc;
        w_ftail_nx    = 1'b0;
        w_enter_fetch = 1'b0;
        bus.mem_addr  = r_rc;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 8'h00;
        bus.dec_in    = 8'h00;
        bus.dec_a     = 8'h00;
        bus.dec_b     = 8'h00;
        case (r_state)
            LOAD: begin
                bus.mem_we    = bus.load_valid;
                bus.mem_wdata = bus.load_row;
                if (bus.load_valid) begin
                    w_rc_nx = r_rc + 3'd1;
                    if (r_rc == 3'd7) w_state_nx = DISPLAY;
                end
            end
            DISPLAY: begin
                w_rc_nx = r_rc + 3'd1;
                if (r_rc == 3'd7) begin
                    if (bus.load_req) w_state_nx = LOAD;
                    else if (r_fc == FC_LAST && (bus.run || r_step_pend)) begin
                        w_state_nx    = FETCH;
                        w_fc_nx       = 8'd0;
                        w_enter_fetch = 1'b1;
                    end else w_fc_nx = (r_fc == FC_LAST) ? 8'd0 : r_fc + 8'd1;
                end
            end
            FETCH: begin
                // the ninth cycle only captures the row-7 read data
                w_rc_nx    = r_ftail ? 3'd0 : r_rc + 3'd1;
                w_ftail_nx = !r_ftail && r_rc == 3'd7;
                if (r_ftail) w_state_nx = UPDATE;
            end
            UPDATE: begin
                bus.dec_in    = r_shadow[r_rc];
                bus.dec_a     = r_shadow[r_rc - 3'd1];
                bus.dec_b     = r_shadow[r_rc + 3'd1];
                bus.mem_we    = 1'b1;
                bus.mem_wdata = bus.dec_out;
                w_rc_nx       = r_rc + 3'd1;
                if (r_rc == 3'd7) begin
                    w_state_nx = DISPLAY;
                    w_fc_nx    = 8'd0;
                end
            end
        endcase
    end

    // state register plus step latch, generation counter and display strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LOAD;
            r_rc         <= 3'd0;
            r_fc         <= 8'd0;
            r_ftail      <= 1'b0;
            r_step_pend  <= 1'b0;
            r_gen_count  <= 16'd0;
            r_gen_done   <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_addr  <= 3'd0;
        end else begin
            r_state      <= w_state_nx;
            r_rc         <= w_rc_nx;
            r_fc         <= w_fc_nx;
            r_ftail      <= w_ftail_nx;
            r_step_pend  <= (r_step_pend | bus.step) & ~w_enter_fetch;
            r_gen_done   <= w_last_update;
            r_gen_count  <= w_last_update ? r_gen_count + 16'd1 : r_gen_count;
            r_disp_valid <= r_state == DISPLAY;
            r_disp_addr  <= r_rc;
        end
    end

    // shadow copy of the board, filled one cycle behind each FETCH address
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_shadow[i] <= 8'h00;
        end else if (r_state == FETCH && (r_ftail || r_rc != 3'd0)) begin
            r_shadow[r_rc - 3'd1] <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_gen_sequencer.sv
// tb_gen_sequencer: Life sequencer bench with board memory, row decoder and whole-board reference model
module tb_gen_sequencer;
    localparam int N = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gen_sequencer_if bus();
    gen_sequencer #(.FRAMES_PER_GEN(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    logic [7:0] mem [8];
    int total = 0;
    int bad = 0;
    int dec_leak = 0;
    logic [7:0] cap_in, cap_a, cap_b, cap_w;

    typedef struct {
        logic [63:0] seed;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl [6];

    // board memory with one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // single-row Life decoder with horizontal wrap
    function automatic logic [7:0] row_next(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
        int n;
        int k;
        row_next = 8'h00;
        for (int j = 0; j < 8; j++) begin
            n = 0;
            for (int d = -1; d <= 1; d++) begin
                k = (j + d + 8) % 8;
                n += int'(a[k]);
                n += int'(b[k]);
                if (d != 0) n += int'(c[k]);
            end
            row_next[j] = (n == 3) || (c[j] && n == 2);
        end
    endfunction
    assign bus.dec_out = row_next(bus.dec_in, bus.dec_a, bus.dec_b);

    // reference: one generation of the 8x8 torus, row r at bits [8r +: 8]
    function automatic logic [63:0] life_ref(input logic [63:0] b);
        int n;
        life_ref = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) n += int'(b[((r + dr + 8) % 8) * 8 + (c + dc + 8) % 8]);
                life_ref[r * 8 + c] = (n == 3) || (b[r * 8 + c] && n == 2);
            end
    endfunction

    // UPDATE row-0 snapshot and decoder-idle watch
    always @(negedge clk) begin
        if (bus.busy && bus.mem_we && bus.mem_addr == 3'd0) begin
            cap_in = bus.dec_in;
            cap_a  = bus.dec_a;
            cap_b  = bus.dec_b;
            cap_w  = bus.mem_wdata;
        end
        if (!(bus.busy && bus.mem_we) && (bus.dec_in | bus.dec_a | bus.dec_b) != 8'h00) dec_leak++;
    end

    function automatic logic [63:0] mem_board();
        for (int r = 0; r < 8; r++) mem_board[r * 8 +: 8] = mem[r];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_board(input logic [63:0] b);
        int k;
        k = 0;
        while (!bus.load_ready && k < 50) begin
            tick();
            k++;
        end
        check("load_ready_wait", 64'(bus.load_ready), 64'd1);
        for (int r = 0; r < 8; r++) begin
            bus.load_valid = 1'b1;
            bus.load_row   = b[r * 8 +: 8];
            tick();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.gen_done && cyc < budget);
        check("gen_done_seen", 64'(bus.gen_done), 64'd1);
    endtask

    task automatic wait_update_row(input logic [2:0] row, input int budget);
        int k;
        k = 0;
        while (!(bus.busy && bus.mem_we && bus.mem_addr == row) && k < budget) begin
            tick();
            k++;
        end
        check("update_row_seen", 64'(bus.busy && bus.mem_we && bus.mem_addr == row), 64'd1);
    endtask

    task automatic run_gen(input logic [63:0] seed, input bit use_run);
        int cyc;
        do_reset();
        load_board(seed);
        if (use_run) bus.run = 1'b1;
        else begin
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
        end
        wait_done(200, cyc);
        bus.run = 1'b0;
        tick();
        check("gen_done_single", 64'(bus.gen_done), 64'd0);
        for (int i = 0; i < 40; i++) tick();
        check("gen_count_one", 64'(bus.gen_count), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int nval;
        bit seq_ok;
        logic [2:0] exp_addr;
        logic [63:0] b, g1;
        logic [15:0] gc;
        int k;

        bus.load_valid = 1'b0;
        bus.load_row   = 8'h00;
        bus.load_req   = 1'b0;
        bus.run        = 1'b0;
        bus.step       = 1'b0;
        reset          = 1'b1;

        tbl[0] = '{64'h0000_0008_0808_0000, 64'h0000_0000_1C00_0000};
        tbl[1] = '{64'h0800_0000_0000_0808, 64'h0000_0000_0000_001C};
        tbl[2] = '{64'h0000_0018_1800_0000, 64'h0000_0018_1800_0000};
        tbl[3] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
        tbl[4] = '{64'h0000_0E00_0000_0000, 64'h0004_0404_0000_0000};
        tbl[5] = '{64'h0000_0000_00C1_0000, 64'h0000_0000_8080_8000};

        do_reset();
        check("rst_load_ready", 64'(bus.load_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_gen_count", 64'(bus.gen_count), 64'd0);
        check("rst_gen_done", 64'(bus.gen_done), 64'd0);
        check("rst_disp_valid", 64'(bus.disp_valid), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_gen(tbl[i].seed, 1'b0);
            check($sformatf("vec%0d_board", i), mem_board(), tbl[i].exp);
            if (i == 1) begin
                check("wrap_dec_in", 64'(cap_in), 64'h08);
                check("wrap_dec_a", 64'(cap_a), 64'h08);
                check("wrap_dec_b", 64'(cap_b), 64'h08);
                check("wrap_row0", 64'(cap_w), 64'h1C);
            end
        end

        b = tbl[0].seed;
        do_reset();
        load_board(b);
        bus.run = 1'b1;
        wait_done(200, cyc);
        check("run_gen1_board", mem_board(), life_ref(b));
        cyc = 0;
        nval = 0;
        seq_ok = 1'b1;
        exp_addr = 3'd0;
        do begin
            tick();
            cyc++;
            if (bus.disp_valid) begin
                if (bus.disp_addr != exp_addr || bus.disp_row != life_ref(b)[exp_addr * 8 +: 8]) seq_ok = 1'b0;
                exp_addr++;
                nval++;
            end
        end while (!bus.gen_done && cyc < 100);
        check("run_period", 64'(cyc), 64'd33);
        check("run_disp_count", 64'(nval), 64'd16);
        check("run_disp_seq", 64'(seq_ok), 64'd1);
        check("run_gen2_board", mem_board(), life_ref(life_ref(b)));

        gc = bus.gen_count;
        k = 0;
        while (!(bus.disp_valid && bus.disp_addr == 3'd7) && k < 20) begin
            tick();
            k++;
        end
        bus.load_req = 1'b1;
        tick();
        k = 0;
        while (!(bus.disp_valid && bus.disp_addr == 3'd7) && k < 20) begin
            tick();
            k++;
        end
        check("ldreq_disp7_seen", 64'(bus.disp_valid && bus.disp_addr == 3'd7), 64'd1);
        check("ldreq_load_ready", 64'(bus.load_ready), 64'd1);
        check("ldreq_busy", 64'(bus.busy), 64'd0);
        bus.load_req = 1'b0;
        bus.run = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("ldreq_gen_count", 64'(bus.gen_count), 64'(gc));
        check("ldreq_still_load", 64'(bus.load_ready), 64'd1);

        b = 64'h0000_0000_0007_0402;
        do_reset();
        load_board(b);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        wait_done(200, cyc);
        g1 = life_ref(b);
        check("rstmid_gen1_board", mem_board(), g1);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        wait_update_row(3'd3, 200);
        reset = 1'b1;
        tick();
        check("rstmid_load_ready", 64'(bus.load_ready), 64'd1);
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_gen_count", 64'(bus.gen_count), 64'd0);
        reset = 1'b0;
        nval = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.gen_done) nval++;
            tick();
        end
        check("rstmid_no_done", 64'(nval), 64'd0);
        check("rstmid_partial_board", mem_board(), {g1[63:32], life_ref(g1)[31:0]});

        for (int i = 0; i < 12; i++) begin
            b = {$urandom, $urandom};
            run_gen(b, 1'($urandom_range(0, 1)));
            check($sformatf("rand%0d_board", i), mem_board(), life_ref(b));
        end

        check("dec_idle_zero", 64'(dec_leak), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
